connect4_turn_arbiter: RTL and testbench



---
 rtl/connect4_turn_arbiter.sv | 134 +++++++++++++
 tb/tb_connect4_turn_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/connect4_turn_arbiter.sv
// connect4_turn_arbiter: shares one connect4 engine port between two alternating players
module connect4_turn_arbiter #(
  parameter int TURN_TIMEOUT = 1000,
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p0_valid,
  input  logic [2:0] p0_col,
  output logic       p0_ready,
  input  logic       p1_valid,
  input  logic [2:0] p1_col,
  output logic       p1_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_player,
  output logic       rsp_err,
  output logic       rsp_finished,
  output logic       rsp_winner,
  output logic       rsp_tie,
  output logic       eng_op_valid,
  input  logic       eng_op_ready,
  output logic       eng_op_player_id,
  output logic [2:0] eng_op_col_id,
  output logic       eng_re_ready,
  input  logic       eng_re_valid,
  input  logic       eng_re_err,
  input  logic       eng_re_is_finished,
  input  logic       eng_re_winner,
  input  logic       eng_re_tie,
  output logic       turn,
  output logic [5:0] move_cnt,
  output logic [7:0] game_cnt,
  output logic       turn_timeout
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RE, S_RSP} state_t;
  localparam logic [15:0] WD_LAST = 16'(TURN_TIMEOUT - 1);
  state_t      r_state, w_next;
  logic        r_turn, r_start, r_op_player, r_rsp_player;
  logic [2:0]  r_op_col;
  logic        r_err, r_fin, r_win, r_tie, r_timeout;
  logic [5:0]  r_move_cnt;
  logic [7:0]  r_game_cnt;
  logic [15:0] r_wd;
  logic        w_p_fire, w_op_fire, w_re_fire, w_rsp_fire;
  assign p0_ready         = (r_state == S_IDLE) && !r_turn;
  assign p1_ready         = (r_state == S_IDLE) && r_turn;
  assign eng_op_valid     = (r_state == S_ISSUE);
  assign eng_re_ready     = (r_state == S_WAIT_RE);
  assign rsp_valid        = (r_state == S_RSP);
  assign w_p_fire         = r_turn ? (p1_valid && p1_ready) : (p0_valid && p0_ready);
  assign w_op_fire        = eng_op_valid && eng_op_ready;
  assign w_re_fire        = eng_re_valid && eng_re_ready;
  assign w_rsp_fire       = rsp_valid && rsp_ready;
  assign eng_op_player_id = r_op_player;
  assign eng_op_col_id    = r_op_col;
  assign rsp_player       = r_rsp_player;
  assign rsp_err          = r_err;
  assign rsp_finished     = r_fin;
  assign rsp_winner       = r_win;
  assign rsp_tie          = r_tie;
  assign turn             = r_turn;
  assign move_cnt         = r_move_cnt;
  assign game_cnt         = r_game_cnt;
  assign turn_timeout     = r_timeout;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // next state: each phase advances only on its own handshake
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = w_p_fire   ? S_ISSUE   : S_IDLE;
      S_ISSUE:   w_next = w_op_fire  ? S_WAIT_RE : S_ISSUE;
      S_WAIT_RE: w_next = w_re_fire  ? S_RSP     : S_WAIT_RE;
      default:   w_next = w_rsp_fire ? S_IDLE    : S_RSP;
    endcase
  end
  // move latch, result capture and turn/counter bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_turn       <= FIRST_PLAYER;
      r_start      <= FIRST_PLAYER;
      r_op_player  <= 1'b0;
      r_op_col     <= 3'd0;
      r_rsp_player <= 1'b0;
      r_err        <= 1'b0;
      r_fin        <= 1'b0;
      r_win        <= 1'b0;
      r_tie        <= 1'b0;
      r_move_cnt   <= 6'd0;
      r_game_cnt   <= 8'd0;
    end else begin
      if (w_p_fire) begin
        r_op_player <= r_turn;
        r_op_col    <= r_turn ? p1_col : p0_col;
      end
      if (w_re_fire) begin
        r_rsp_player <= r_op_player;
        r_err        <= eng_re_err;
        r_fin        <= eng_re_is_finished;
        r_win        <= eng_re_winner;
        r_tie        <= eng_re_tie;
      end
      if (w_rsp_fire && r_fin) begin
        r_move_cnt <= 6'd0;
        r_game_cnt <= r_game_cnt + 8'd1;
        r_start    <= ~r_start;
        r_turn     <= ~r_start;
      end else if (w_rsp_fire && !r_err) begin
        r_move_cnt <= r_move_cnt + 6'(r_move_cnt != 6'd42);
        r_turn     <= ~r_turn;
      end
    end
  end
  // idle watchdog: counts only while waiting for the current player
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd      <= 16'd0;
      r_timeout <= 1'b0;
    end else if (TURN_TIMEOUT == 0 || r_state != S_IDLE || w_p_fire) begin
      r_wd      <= 16'd0;
      r_timeout <= 1'b0;
    end else if (r_wd == WD_LAST) begin
      r_wd      <= 16'd0;
      r_timeout <= 1'b1;
    end else begin
      r_wd      <= r_wd + 16'd1;
      r_timeout <= 1'b0;
    end
  end
endmodule

// File: tb/tb_connect4_turn_arbiter.sv
// tb_connect4_turn_arbiter: directed checks of turn arbitration, counters, back-pressure and watchdog
module tb_connect4_turn_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p0_valid = 1'b0, p1_valid = 1'b0;
  logic [2:0] p0_col = 3'd0, p1_col = 3'd0;
  logic       p0_ready, p1_ready;
  logic       rsp_valid, rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie;
  logic       rsp_ready = 1'b0;
  logic       eng_op_valid, eng_op_player_id, eng_re_ready;
  logic [2:0] eng_op_col_id;
  logic       eng_op_ready = 1'b0;
  logic       eng_re_valid = 1'b0, eng_re_err = 1'b0, eng_re_is_finished = 1'b0;
  logic       eng_re_winner = 1'b0, eng_re_tie = 1'b0;
  logic       turn, turn_timeout;
  logic [5:0] move_cnt;
  logic [7:0] game_cnt;
  int         checks = 0;
  int         failures = 0;
  connect4_turn_arbiter #(.TURN_TIMEOUT(10), .FIRST_PLAYER(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_col(p0_col), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_col(p1_col), .p1_ready(p1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_player(rsp_player),
    .rsp_err(rsp_err), .rsp_finished(rsp_finished), .rsp_winner(rsp_winner), .rsp_tie(rsp_tie),
    .eng_op_valid(eng_op_valid), .eng_op_ready(eng_op_ready),
    .eng_op_player_id(eng_op_player_id), .eng_op_col_id(eng_op_col_id),
    .eng_re_ready(eng_re_ready), .eng_re_valid(eng_re_valid), .eng_re_err(eng_re_err),
    .eng_re_is_finished(eng_re_is_finished), .eng_re_winner(eng_re_winner), .eng_re_tie(eng_re_tie),
    .turn(turn), .move_cnt(move_cnt), .game_cnt(game_cnt), .turn_timeout(turn_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_outputs(input string tag, input logic exp_turn, input logic [5:0] exp_mc, input logic [7:0] exp_gc);
    chk({tag, "_p0_ready"}, p0_ready, !exp_turn);
    chk({tag, "_p1_ready"}, p1_ready, exp_turn);
    chk({tag, "_turn"}, turn, exp_turn);
    chk({tag, "_move_cnt"}, move_cnt, exp_mc);
    chk({tag, "_game_cnt"}, game_cnt, exp_gc);
    chk({tag, "_op_valid"}, eng_op_valid, 0);
    chk({tag, "_re_ready"}, eng_re_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
  endtask
  task automatic move(input string tag, input logic p, input logic [2:0] col,
                      input logic err, input logic fin, input logic win, input logic tie,
                      input int op_dly, input int rsp_dly,
                      input logic exp_turn, input logic [5:0] exp_mc, input logic [7:0] exp_gc);
    chk({tag, "_my_ready"}, p ? p1_ready : p0_ready, 1);
    if (p) begin p1_valid = 1'b1; p1_col = col; end
    else   begin p0_valid = 1'b1; p0_col = col; end
    step();
    p0_valid = 1'b0; p1_valid = 1'b0; p0_col = ~col; p1_col = ~col;
    chk({tag, "_op_valid"}, eng_op_valid, 1);
    chk({tag, "_op_id"}, eng_op_player_id, p);
    chk({tag, "_op_col"}, eng_op_col_id, col);
    chk({tag, "_busy_ready"}, {p0_ready, p1_ready}, 0);
    for (int i = 0; i < op_dly; i++) begin
      step();
      chk({tag, "_op_hold_valid"}, eng_op_valid, 1);
      chk({tag, "_op_hold_pl"}, {eng_op_player_id, eng_op_col_id}, {p, col});
      chk({tag, "_op_hold_re_ready"}, eng_re_ready, 0);
    end
    eng_op_ready = 1'b1;
    step();
    eng_op_ready = 1'b0;
    chk({tag, "_op_done"}, eng_op_valid, 0);
    chk({tag, "_re_ready"}, eng_re_ready, 1);
    eng_re_valid = 1'b1; eng_re_err = err; eng_re_is_finished = fin;
    eng_re_winner = win; eng_re_tie = tie;
    step();
    eng_re_valid = 1'b0; eng_re_err = 1'b0; eng_re_is_finished = 1'b0;
    eng_re_winner = 1'b0; eng_re_tie = 1'b0;
    chk({tag, "_re_done"}, eng_re_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_player"}, rsp_player, p);
    chk({tag, "_rsp_bits"}, {rsp_err, rsp_finished, rsp_winner, rsp_tie}, {err, fin, win, tie});
    for (int i = 0; i < rsp_dly; i++) begin
      step();
      chk({tag, "_rsp_hold_valid"}, rsp_valid, 1);
      chk({tag, "_rsp_hold_pl"}, {rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie},
          {p, err, fin, win, tie});
      chk({tag, "_rsp_hold_op"}, eng_op_valid, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    idle_outputs(tag, exp_turn, exp_mc, exp_gc);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_outputs("reset", 0, 0, 0);
    chk("reset_timeout", turn_timeout, 0);
    chk("reset_op_pl", {eng_op_player_id, eng_op_col_id}, 0);
    chk("reset_rsp_pl", {rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie}, 0);
    p1_valid = 1'b1;
    p1_col = 3'd5;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("offturn_p1_ready", p1_ready, 0);
      chk("offturn_op_valid", eng_op_valid, 0);
      chk("wd_pulse", turn_timeout, (k % 10) == 0);
    end
    p1_valid = 1'b0;
    move("m1_p0", 0, 3'd3, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    move("m2_p1_err", 1, 3'd4, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    move("m2_p1", 1, 3'd4, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    move("m3_p0_bp", 0, 3'd6, 0, 0, 0, 0, 5, 3, 1, 3, 0);
    move("m4_p1", 1, 3'd0, 0, 0, 0, 0, 1, 0, 0, 4, 0);
    move("m5_p0", 0, 3'd3, 0, 0, 0, 0, 0, 1, 1, 5, 0);
    move("m6_p1", 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    move("m7_p0_win", 0, 3'd3, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    move("g2_p1_tie", 1, 3'd1, 0, 1, 0, 1, 0, 0, 0, 0, 2);
    move("g3_p0", 0, 3'd2, 0, 0, 0, 0, 0, 0, 1, 1, 2);
    p1_valid = 1'b1;
    p1_col = 3'd6;
    step();
    p1_valid = 1'b0;
    eng_op_ready = 1'b1;
    step();
    eng_op_ready = 1'b0;
    chk("pre_rst_re_ready", eng_re_ready, 1);
    chk("pre_rst_col", eng_op_col_id, 6);
    rst_n = 1'b0;
    #1;
    idle_outputs("async_rst", 0, 0, 0);
    chk("async_rst_op_pl", {eng_op_player_id, eng_op_col_id}, 0);
    chk("async_rst_timeout", turn_timeout, 0);
    step();
    rst_n = 1'b1;
    step();
    idle_outputs("post_rst", 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
